muldiv_stage: RTL and testbench

Parametrised iterative multiply/divide execute stage for the RV32M/RV64M extension. It sits beside the ALU stage behind ISSUE and forwards the uop with its result toward MEM/Retire. Unlike the single-cycle ALU stage, it has a generic `XLEN`, a multi-cycle datapath and a valid/ready handshake on both sides instead of a global stall. It handles the RISC-V divide-by-zero and signed-overflow corner cases in a one-cycle fast path.

---
 rtl/riscv_uop_pkg.sv | 41 ++++
 rtl/muldiv_stage_core.sv | 115 +++++++++++
 rtl/muldiv_stage.sv | 112 +++++++++++
 tb/tb_muldiv_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_uop_pkg.sv
// Shared uop definitions for the execute stages, plus the multiply/divide
// operation encoding and small helpers used by muldiv_stage.
package riscv_uop_pkg;

    // Encoded exactly as the RV32M/RV64M funct3 field.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    // Micro-op bookkeeping carried alongside the result toward MEM/Retire.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [5:0]  tag;
        logic        wb_en;
    } uop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic op1_signed(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM (not MULHSU).
    function automatic logic op2_signed(input md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_stage_core.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiplier and
// restoring divider running on operand magnitudes, with the final sign
// fix-up applied on the last iteration. One bit per cycle, XLEN cycles.
module muldiv_core
    import riscv_uop_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  md_op_e          op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    // Magnitude of a two's-complement value when its sign flag is set.
    function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v, input logic neg);
        return neg ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    md_op_e            op_q;
    logic              neg1;
    logic              neg2;
    logic [XLEN-1:0]   operand;     // |multiplicand| or |divisor|
    logic [2*XLEN-1:0] acc;         // product accumulator, multiplier in low half
    logic [XLEN-1:0]   quo;         // dividend shifting out / quotient shifting in
    logic [XLEN:0]     rem;         // partial remainder

    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN+1:0]   shifted;
    logic [XLEN+1:0]   diff;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [2*XLEN-1:0] prod_fix;
    logic              last;

    assign last = (cnt == CNT_W'(XLEN - 1));
    assign done = busy && last;

    // One multiply step and one restoring-divide step, plus the signed result.
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        acc_next = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

        shifted  = {rem, quo[XLEN-1]};
        diff     = shifted - {2'b00, operand};
        if (!diff[XLEN+1]) begin
            rem_next = diff[XLEN:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end

        prod_fix = (neg1 ^ neg2) ? -acc_next : acc_next;

        result = '0;
        case (op_q)
            MD_MUL:                     result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:            result = (neg1 ^ neg2) ? -quo_next : quo_next;
            MD_REM, MD_REMU:            result = neg1 ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
            default:                    result = '0;
        endcase
    end

    // Control: busy flag and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (kill) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (last) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Datapath: load magnitudes on start, then advance one bit per cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            op_q    <= op;
            neg1    <= op1_signed(op) & op1[XLEN-1];
            neg2    <= op2_signed(op) & op2[XLEN-1];
            acc     <= {{XLEN{1'b0}}, mag(op2, op2_signed(op) & op2[XLEN-1])};
            quo     <= mag(op1, op1_signed(op) & op1[XLEN-1]);
            rem     <= '0;
            operand <= op[2] ? mag(op2, op2_signed(op) & op2[XLEN-1])
                             : mag(op1, op1_signed(op) & op1[XLEN-1]);
        end else if (busy) begin
            acc <= acc_next;
            quo <= quo_next;
            rem <= rem_next;
        end
    end

endmodule

// File: rtl/muldiv_stage.sv
// Multiply/divide execute stage: valid/ready handshake on both sides, an
// IDLE/CALC/DONE controller around muldiv_core, a one-cycle path for the
// divide-by-zero and signed-overflow cases, and the registered result/uop.
module muldiv_stage
    import riscv_uop_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  md_op_e          i_md_op,
    input  uop_t            i_uop,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output uop_t            o_uop_forward,
    output logic            o_busy
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state;
    logic            accept;
    logic            fast;
    logic [XLEN-1:0] fast_res;
    logic            core_done;
    logic [XLEN-1:0] core_result;

    assign o_ready = (state == ST_IDLE);
    assign o_busy  = (state != ST_IDLE);
    assign accept  = i_valid && o_ready && !i_flush;

    // Division corner cases resolved without iterating.
    always_comb begin
        fast     = 1'b0;
        fast_res = '0;
        if (i_md_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) begin
            if (i_op2 == '0) begin
                fast     = 1'b1;
                fast_res = (i_md_op inside {MD_REM, MD_REMU}) ? i_op1 : '1;
            end else if ((i_md_op inside {MD_DIV, MD_REM}) && i_op1 == MIN_INT && i_op2 == '1) begin
                fast     = 1'b1;
                fast_res = (i_md_op == MD_DIV) ? MIN_INT : '0;
            end
        end
    end

    muldiv_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && !fast),
        .kill   (i_flush),
        .op     (i_md_op),
        .op1    (i_op1),
        .op2    (i_op2),
        .done   (core_done),
        .result (core_result)
    );

    // Stage controller with registered valid, result and uop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            o_valid       <= 1'b0;
            o_result      <= '0;
            o_uop_forward <= '0;
        end else if (i_flush) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        o_uop_forward <= i_uop;
                        if (fast) begin
                            o_result <= fast_res;
                            o_valid  <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (core_done) begin
                        o_result <= core_result;
                        o_valid  <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_stage.sv
// Directed bench for muldiv_stage (XLEN=32 instance plus an XLEN=64 instance).
module tb_muldiv_stage;
    import riscv_uop_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_valid, i_flush, i_ready;
    logic [31:0] i_op1, i_op2;
    md_op_e      i_md_op;
    uop_t        i_uop;
    logic        o_ready, o_valid, o_busy;
    logic [31:0] o_result;
    uop_t        o_uop_forward;

    logic        v64_valid, v64_ready_in, v64_ready, v64_out_valid, v64_busy;
    logic [63:0] v64_op1, v64_op2, v64_result;
    md_op_e      v64_md_op;
    uop_t        v64_uop, v64_uop_forward;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op1(i_op1), .i_op2(i_op2), .i_md_op(i_md_op), .i_uop(i_uop),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_uop_forward(o_uop_forward), .o_busy(o_busy)
    );

    muldiv_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .i_valid(v64_valid), .o_ready(v64_ready),
        .i_op1(v64_op1), .i_op2(v64_op2), .i_md_op(v64_md_op), .i_uop(v64_uop),
        .i_flush(1'b0), .o_valid(v64_out_valid), .i_ready(v64_ready_in),
        .o_result(v64_result), .o_uop_forward(v64_uop_forward), .o_busy(v64_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic uop_t mk_uop(input int n);
        uop_t u;
        u.pc    = 32'h1000_0000 | 32'(n * 4);
        u.rd    = 5'(n);
        u.tag   = 6'(n + 7);
        u.wb_en = 1'b1;
        return u;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept at the next edge; afterwards the bench is in cycle 1.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input int n);
        i_md_op = op; i_op1 = a; i_op2 = b; i_uop = mk_uop(n); i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        // Operands are only sampled at accept; scramble them afterwards.
        i_op1 = $urandom; i_op2 = $urandom; i_md_op = MD_MULHU; i_uop = mk_uop(n + 50);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!o_valid && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] exp, input int lat);
        int cyc;
        issue(op, a, b, n);
        wait_valid(cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_res"}, 64'(o_result), 64'(exp));
        check({tag, "_uop"}, 64'(o_uop_forward), 64'(mk_uop(n)));
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check({tag, "_idle"}, 64'({o_ready, o_valid}), 64'b10);
    endtask

    initial begin
        int cyc;
        logic saw;
        rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_op1 = '0; i_op2 = '0; i_md_op = MD_MUL; i_uop = '0;
        v64_valid = 1'b0; v64_ready_in = 1'b0; v64_op1 = '0; v64_op2 = '0;
        v64_md_op = MD_MUL; v64_uop = '0;
        step(); step();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_uop", 64'(o_uop_forward), 64'd0);
        rst = 1'b0;
        step();

        // Multiply
        run_op("mul",    MD_MUL,    32'd7,        32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 33);
        run_op("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 33);
        run_op("mulh",   MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'h0000_0000, 33);
        run_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF, 33);

        // Divide
        run_op("div",  MD_DIV,  32'hFFFF_FFF9, 32'd2, 5, 32'hFFFF_FFFD, 33);
        run_op("rem",  MD_REM,  32'hFFFF_FFF9, 32'd2, 6, 32'hFFFF_FFFF, 33);
        run_op("divu", MD_DIVU, 32'd100,       32'd7, 7, 32'd14,        33);
        run_op("remu", MD_REMU, 32'd100,       32'd7, 8, 32'd2,         33);

        // Corner cases on the fast path
        run_op("div0",  MD_DIV, 32'h0000_0055, 32'd0,         9,  32'hFFFF_FFFF, 1);
        run_op("rem0",  MD_REM, 32'h0000_1234, 32'd0,         10, 32'h0000_1234, 1);
        run_op("divov", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 11, 32'h8000_0000, 1);
        run_op("remov", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 12, 32'h0000_0000, 1);

        // Backpressure in DONE
        issue(MD_DIVU, 32'd100, 32'd7, 20);
        wait_valid(cyc);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid",  64'(o_valid), 64'd1);
            check("bp_result", 64'(o_result), 64'd14);
            check("bp_uop",    64'(o_uop_forward), 64'(mk_uop(20)));
            check("bp_ready",  64'(o_ready), 64'd0);
            step();
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("bp_release", 64'({o_ready, o_valid, o_busy}), 64'b100);

        // Flush mid-CALC at cycle 10
        issue(MD_MUL, 32'd123, 32'd456, 30);
        repeat (9) step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("fl_ready", 64'({o_ready, o_busy}), 64'b10);
        saw = 1'b0;
        repeat (40) begin
            if (o_valid) saw = 1'b1;
            step();
        end
        check("fl_no_valid", 64'(saw), 64'd0);
        run_op("fl_next", MD_MUL, 32'd5, 32'd6, 31, 32'd30, 33);

        // Flush coinciding with accept (would otherwise be a fast-path op)
        i_md_op = MD_DIV; i_op1 = 32'd9; i_op2 = 32'd0; i_uop = mk_uop(40);
        i_valid = 1'b1; i_flush = 1'b1;
        step();
        i_valid = 1'b0; i_flush = 1'b0;
        check("flacc_state", 64'({o_ready, o_busy}), 64'b10);
        saw = 1'b0;
        repeat (40) begin
            if (o_valid) saw = 1'b1;
            step();
        end
        check("flacc_no_valid", 64'(saw), 64'd0);

        // Reset mid-CALC
        issue(MD_MULHU, 32'hFFFF_FFFF, 32'h3, 45);
        repeat (5) step();
        rst = 1'b1;
        step();
        check("rmid_valid",  64'(o_valid), 64'd0);
        check("rmid_ready",  64'(o_ready), 64'd1);
        check("rmid_busy",   64'(o_busy), 64'd0);
        check("rmid_result", 64'(o_result), 64'd0);
        check("rmid_uop",    64'(o_uop_forward), 64'd0);
        rst = 1'b0;
        step();

        // XLEN=64 build
        v64_md_op = MD_MULHU; v64_op1 = '1; v64_op2 = '1; v64_uop = mk_uop(60);
        v64_valid = 1'b1;
        step();
        v64_valid = 1'b0; v64_op1 = '0; v64_op2 = '0;
        cyc = 1;
        while (!v64_out_valid && cyc < 200) begin
            step();
            cyc++;
        end
        check("x64_lat", 64'(cyc), 64'd65);
        check("x64_res", v64_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("x64_uop", 64'(v64_uop_forward), 64'(mk_uop(60)));
        v64_ready_in = 1'b1;
        step();
        v64_ready_in = 1'b0;
        check("x64_idle", 64'({v64_ready, v64_out_valid}), 64'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
